// File: rtl/lb_smm.sv
// lb_smm: lookup-based 4x4 sign-magnitude multiplier with a registered 7-bit sign-magnitude product.
// Define LBSMM_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module lb_smm (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       out_valid,
  output logic [6:0] result
);
  localparam logic [5:0] lut [64] = '{
    6'd0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,
    6'd0, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd7,
    6'd0, 6'd2,  6'd4,  6'd6,  6'd8,  6'd10, 6'd12, 6'd14,
    6'd0, 6'd3,  6'd6,  6'd9,  6'd12, 6'd15, 6'd18, 6'd21,
    6'd0, 6'd4,  6'd8,  6'd12, 6'd16, 6'd20, 6'd24, 6'd28,
    6'd0, 6'd5,  6'd10, 6'd15, 6'd20, 6'd25, 6'd30, 6'd35,
    6'd0, 6'd6,  6'd12, 6'd18, 6'd24, 6'd30, 6'd36, 6'd42,
    6'd0, 6'd7,  6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49
  };
  logic [3:0] a_s, b_s;
  logic       v_s;
  logic [5:0] mag;
  logic       sgn;
`ifdef LBSMM_INPUT_REG_EN
  always_ff @(posedge clk)
    if (rst) begin
      a_s <= '0;
      b_s <= '0;
      v_s <= 1'b0;
    end else begin
      a_s <= A;
      b_s <= B;
      v_s <= in_valid;
    end
`else
  assign a_s = A;
  assign b_s = B;
  assign v_s = in_valid;
`endif
  assign mag = lut[{a_s[2:0], b_s[2:0]}];
  // a zero magnitude (including a -0 operand) always yields +0
  assign sgn = (a_s[3] ^ b_s[3]) & |mag;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= v_s;
      if (v_s) result <= {sgn, mag};
    end
endmodule

// File: tb/tb_lb_smm.sv
// tb_lb_smm: self-checking bench for lb_smm against a signed-arithmetic reference model.
module tb_lb_smm;
`ifdef LBSMM_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [3:0] A, B;
  logic       out_valid;
  logic [6:0] result;
  int errors = 0, checks = 0;
  typedef struct packed {logic v; logic [6:0] p;} item_t;
  item_t pipe[$];
  logic       exp_v;
  logic [6:0] exp_r;

  lb_smm dut (.clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
              .out_valid(out_valid), .result(result));

  always #5 clk = ~clk;

  function automatic logic [3:0] enc(int x);
    return x < 0 ? {1'b1, 3'(-x)} : {1'b0, 3'(x)};
  endfunction

  function automatic logic [6:0] prod(logic [3:0] a, logic [3:0] b);
    int sa, sb, p;
    sa = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
    sb = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
    p = sa * sb;
    return p < 0 ? {1'b1, 6'(-p)} : {1'b0, 6'(p)};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    item_t head;
    rst = r; in_valid = v; A = a; B = b;
    @(posedge clk);
    if (r) begin
      pipe.delete();
      for (int i = 0; i < LAT - 1; i++) pipe.push_back('0);
      exp_v = 1'b0;
      exp_r = '0;
    end else begin
      pipe.push_back({v, prod(a, b)});
      head = pipe.pop_front();
      exp_v = head.v;
      if (head.v) exp_r = head.p;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("result", 32'(result), 32'(exp_r));
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 4'b0, 4'b0);
  endtask

  initial begin
    int n;
    step(1'b1, 1'b0, 4'b0, 4'b0);
    step(1'b1, 1'b1, 4'b1111, 4'b0111);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    step(1'b0, 1'b0, 4'b0, 4'b0);

    // latency measured by counting edges until out_valid
    step(1'b0, 1'b1, 4'b1011, 4'b1101);
    n = 1;
    while (!out_valid && n < 6) begin
      step(1'b0, 1'b0, 4'b0, 4'b0);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("spot_m3_m5", 32'(result), 32'b0001111);

    step(1'b0, 1'b1, 4'b1111, 4'b0111);
    for (int i = 0; i < LAT - 1; i++) step(1'b0, 1'b0, 4'b0, 4'b0);
    chk("spot_m7_p7", 32'(result), 32'b1110001);

    step(1'b0, 1'b1, 4'b0000, 4'b1111);
    for (int i = 0; i < LAT - 1; i++) step(1'b0, 1'b0, 4'b0, 4'b0);
    chk("zero_pos", 32'(result), 32'd0);

    step(1'b0, 1'b1, 4'b0111, 4'b0111);
    step(1'b0, 1'b1, 4'b1000, 4'b0101);
    for (int i = 0; i < LAT - 1; i++) step(1'b0, 1'b0, 4'b0, 4'b0);
    chk("neg_zero", 32'(result), 32'd0);
    flush();

    for (int a = -7; a <= 7; a++)
      for (int b = -7; b <= 7; b++)
        step(1'b0, 1'b1, enc(a), enc(b));
    chk("exhaustive_last", 32'(prod(enc(7), enc(7))), 32'd49);
    flush();
    chk("exhaustive_hold", 32'(result), 32'd49);

    step(1'b0, 1'b1, enc(2), enc(3));
    step(1'b0, 1'b0, enc(7), enc(7));
    step(1'b0, 1'b1, enc(-4), enc(5));
    step(1'b0, 1'b1, enc(6), enc(-1));
    flush();
    chk("gap_final", 32'(result), 32'b1000110);

    step(1'b0, 1'b1, enc(5), enc(5));
    step(1'b0, 1'b1, enc(-6), enc(3));
    step(1'b1, 1'b1, enc(7), enc(7));
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_result", 32'(result), 32'd0);
    step(1'b0, 1'b1, enc(-5), enc(-6));
    step(1'b0, 1'b1, enc(3), enc(-7));
    flush();
    chk("post_reset", 32'(result), 32'b1010101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
